regfile_wb_arbiter: RTL



---
 rtl/rf_pkg.sv | 9 +
 rtl/wb_pick_two.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Register-file constants shared by the writeback path.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_N_REG  = 32;
  localparam int RF_DATA_W = 16;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;

endpackage

// File: rtl/wb_pick_two.sv
// Combinational picker: walks the sources from start_i and selects up to two
// writers with distinct destinations; x0 requests are flagged for dropping.
module wb_pick_two
  import rf_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]           valid_i,
  input  logic [N_SRC*RF_ADDR_W-1:0] addr_i,
  input  logic [PTR_W-1:0]           start_i,
  output logic [N_SRC-1:0]           grant_1_o,
  output logic [N_SRC-1:0]           grant_2_o,
  output logic [N_SRC-1:0]           drop_o
);

  logic                 found1;
  logic                 found2;
  logic [RF_ADDR_W-1:0] addr1;
  logic [RF_ADDR_W-1:0] cur;
  logic [PTR_W:0]       pos;
  logic [PTR_W-1:0]     idx;

  // Port 2 may never alias port 1's register, so its address is remembered.
  always_comb begin
    grant_1_o = '0;
    grant_2_o = '0;
    drop_o    = '0;
    found1    = 1'b0;
    found2    = 1'b0;
    addr1     = '0;
    cur       = '0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pos = {1'b0, start_i} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(N_SRC)) begin
        pos = pos - (PTR_W+1)'(N_SRC);
      end
      idx = pos[PTR_W-1:0];
      cur = addr_i[idx*RF_ADDR_W +: RF_ADDR_W];
      if (valid_i[idx]) begin
        if (cur == RF_ZERO_ADDR) begin
          drop_o[idx] = 1'b1;
        end else if (!found1) begin
          grant_1_o[idx] = 1'b1;
          found1         = 1'b1;
          addr1          = cur;
        end else if (!found2 && (cur != addr1)) begin
          grant_2_o[idx] = 1'b1;
          found2         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the two register-file write ports from registers.
// Define WB_ARB_RR_EN for round-robin scanning; otherwise source 0 has priority.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int N_SRC  = 3
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*RF_ADDR_W-1:0] src_addr,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      reg_write_1,
  output logic [RF_ADDR_W-1:0]      waddr_1,
  output logic [DATA_W-1:0]         wdata_1,
  output logic                      reg_write_2,
  output logic [RF_ADDR_W-1:0]      waddr_2,
  output logic [DATA_W-1:0]         wdata_2
);

  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0]     grant1;
  logic [N_SRC-1:0]     grant2;
  logic [N_SRC-1:0]     drop;
  logic [PTR_W-1:0]     scanStart;
  logic [RF_ADDR_W-1:0] sel1Addr, sel2Addr;
  logic [DATA_W-1:0]    sel1Data, sel2Data;
  logic                 we1_q, we1_d, we2_q, we2_d;
  logic [RF_ADDR_W-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic [DATA_W-1:0]    wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  wb_pick_two #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid_i   (src_valid),
    .addr_i    (src_addr),
    .start_i   (scanStart),
    .grant_1_o (grant1),
    .grant_2_o (grant2),
    .drop_o    (drop)
  );

  // Dropped x0 requests are acknowledged without occupying a port.
  assign src_ready = grant1 | grant2 | drop;

  always_comb begin
    sel1Addr = '0;
    sel1Data = '0;
    sel2Addr = '0;
    sel2Data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant1[i]) begin
        sel1Addr = src_addr[i*RF_ADDR_W +: RF_ADDR_W];
        sel1Data = src_data[i*DATA_W +: DATA_W];
      end
      if (grant2[i]) begin
        sel2Addr = src_addr[i*RF_ADDR_W +: RF_ADDR_W];
        sel2Data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    we1_d    = |grant1;
    we2_d    = |grant2;
    waddr1_d = we1_d ? sel1Addr : waddr1_q;
    wdata1_d = we1_d ? sel1Data : wdata1_q;
    waddr2_d = we2_d ? sel2Addr : waddr2_q;
    wdata2_d = we2_d ? sel2Data : wdata2_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      waddr2_q <= '0;
      wdata2_q <= '0;
    end else begin
      we1_q    <= we1_d;
      we2_q    <= we2_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
      waddr2_q <= waddr2_d;
      wdata2_q <= wdata2_d;
    end
  end

`ifdef WB_ARB_RR_EN
  logic [PTR_W-1:0] rrPtr_q, rrPtr_d, lastIdx;

  // Port 2's source always follows port 1's in scan order, so it wins when present.
  always_comb begin
    lastIdx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant1[i]) lastIdx = PTR_W'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (grant2[i]) lastIdx = PTR_W'(i);
    end
    rrPtr_d = rrPtr_q;
    if (|grant1) begin
      rrPtr_d = (lastIdx == PTR_W'(N_SRC-1)) ? '0 : lastIdx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rrPtr_q <= '0;
    else         rrPtr_q <= rrPtr_d;
  end

  assign scanStart = rrPtr_q;
`else
  assign scanStart = '0;
`endif

  assign reg_write_1 = we1_q;
  assign waddr_1     = waddr1_q;
  assign wdata_1     = wdata1_q;
  assign reg_write_2 = we2_q;
  assign waddr_2     = waddr2_q;
  assign wdata_2     = wdata2_q;

endmodule
